ram_1r1w_sync: RTL and testbench
================================

Name: ram_1r1w_sync

Overview:
- Parametrised single-clock 1-read/1-write RAM; the successor of the fixed-size ram_RxW macros.
- Adds: configurable depth and width, per-lane write mask, registered 1-cycle read with valid, hardware zero-initialisation after reset, and an optional same-address write-to-read bypass.
- Used for small predictor/queue storage in the core where a known-zero state after reset is required.

Parameters:
- DEPTH, 2, number of entries; must be >= 2.
- WIDTH, 121, data bits per entry.
- MASK_GRAN, 121, bits per write-mask lane; WIDTH must be a multiple of MASK_GRAN.
- Derived: AW = max(1, clog2(DEPTH)); MW = WIDTH/MASK_GRAN.

Ports:
- clock  in  1  sole clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- init_busy  out  1  high while zero-initialisation is in progress.
- R0_addr  in  AW  read address.
- R0_en  in  1  read request.
- R0_data  out  WIDTH  registered read data.
- R0_valid  out  1  R0_data updated by a read accepted in the previous cycle.
- W0_addr  in  AW  write address.
- W0_en  in  1  write request.
- W0_mask  in  MW  lane enables; bit i covers data bits [i*MASK_GRAN +: MASK_GRAN].
- W0_data  in  WIDTH  write data.

Behaviour:
- Single clock domain. Reset is synchronous and active-high.
- Reset values: init_busy=1, R0_valid=0, R0_data=0, init pointer=0, FSM=INIT.
- FSM INIT:
  - Each non-reset cycle writes all-zero to entry[ptr], then ptr++.
  - When the entry at ptr==DEPTH-1 is cleared, go to RUN on the next edge.
  - INIT lasts exactly DEPTH cycles after reset deasserts.
- FSM RUN: init_busy=0. RUN is left only via reset.
- During INIT, R0_en and W0_en are ignored:
  - no user write takes effect;
  - R0_valid stays 0;
  - R0_data holds 0.
- Read, RUN only:
  - R0_en=1 at edge N gives R0_data=mem[R0_addr] and R0_valid=1 after edge N+1 (1-cycle latency).
  - R0_en=0 gives R0_valid=0 next cycle; R0_data holds its last value, never X.
- Write, RUN only: W0_en=1 updates only the lanes with W0_mask[i]=1; other lanes keep their old value. W0_mask=0 means no change.
- Same-address read and write in the same cycle, without the optional feature: read returns the pre-write contents (read-first).
- Out-of-range address (addr >= DEPTH, only possible when DEPTH is not a power of 2): the write is dropped and the read returns 0 with R0_valid=1.
- Reset mid-operation:
  - Reset during INIT restarts the pointer at 0.
  - Reset during RUN re-enters INIT and re-clears every entry.
  - A read or write issued in the reset cycle is discarded.
- No back-pressure: a read can be accepted every cycle and a write can be accepted every cycle.

Optional Feature:
- Macro: RAM_1R1W_BYPASS_EN.
- Defined: same-cycle R0_en and W0_en to the same address in RUN give R0_data = mask-merge of W0_data over the old contents (write-first). Lanes with mask bit 0 show old data.
- Undefined: read-first as above, with no comparator logic.
- The INIT and reset behaviour is identical in both builds.

Test Plan:
- Bench configuration: DEPTH=4, WIDTH=16, MASK_GRAN=8.
- Reset then INIT timing: hold reset 3 cycles, release -> init_busy=1 for exactly 4 cycles then 0; a read of each address 0..3 returns 0x0000 with R0_valid=1 one cycle after R0_en.
- Masked write: write addr 2 data 0xABCD mask 2'b11, then addr 2 data 0x1234 mask 2'b01, then read addr 2 -> R0_data=0xAB34 one cycle later.
- Ignored during INIT: W0_en=1 addr 1 data 0xFFFF in the second INIT cycle -> after INIT, read addr 1 returns 0x0000.
- Same-address collision: addr 3 holds 0x5555; write addr 3 data 0xAAAA mask 2'b10 and read addr 3 in the same cycle -> R0_data=0x5555 without RAM_1R1W_BYPASS_EN, 0xAA55 with it; the next read returns 0xAA55 in both builds.
- Reset in RUN: write 0x7777 to addr 0, pulse reset for 1 cycle -> init_busy=1 for 4 cycles, R0_valid=0 throughout, then read addr 0 returns 0x0000.
- Back-to-back reads: R0_en high for 4 cycles, addresses 0,1,2,3 holding 0x0101..0x0404 -> R0_valid high for 4 cycles starting one cycle later, data in order; R0_en then low -> R0_valid=0 and R0_data holds 0x0404.

Source files
------------

// File: rtl/ram_1r1w_sync.sv
// ram_1r1w_sync: parametrised single-clock 1-read/1-write RAM with per-lane
// write mask, registered 1-cycle read with valid, and hardware
// zero-initialisation after reset (init_busy high while it runs).
// Optional build macro RAM_1R1W_BYPASS_EN: a same-cycle, same-address read and
// write returns the mask-merged write data (write-first). Without it the read
// returns the pre-write contents (read-first) and no address comparator exists.
module ram_1r1w_sync #(
  parameter int unsigned DEPTH     = 2,
  parameter int unsigned WIDTH     = 121,
  parameter int unsigned MASK_GRAN = 121,
  localparam int unsigned AW       = (DEPTH > 2) ? $clog2(DEPTH) : 1,
  localparam int unsigned MW       = WIDTH / MASK_GRAN
) (
  input  logic             clock,
  input  logic             reset,
  output logic             init_busy,
  input  logic [AW-1:0]    R0_addr,
  input  logic             R0_en,
  output logic [WIDTH-1:0] R0_data,
  output logic             R0_valid,
  input  logic [AW-1:0]    W0_addr,
  input  logic             W0_en,
  input  logic [MW-1:0]    W0_mask,
  input  logic [WIDTH-1:0] W0_data
);

  typedef enum logic {StInit, StRun} state_e;

  localparam logic [AW-1:0] LastAddr = AW'(DEPTH - 1);

  state_e           r_state;
  state_e           w_state_d;
  logic [AW-1:0]    r_ptr;
  logic [AW-1:0]    w_ptr_d;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_rd_data;
  logic             r_rd_valid;

  logic             w_run;
  logic             w_rd_in_range;
  logic             w_wr_in_range;
  logic [WIDTH-1:0] w_wr_old;
  logic [WIDTH-1:0] w_wr_merged;
  logic [WIDTH-1:0] w_rd_word;
  logic             w_mem_we;
  logic [AW-1:0]    w_mem_addr;
  logic [WIDTH-1:0] w_mem_wdata;

  assign w_run         = (r_state == StRun);
  assign init_busy     = (r_state == StInit);
  assign w_rd_in_range = (32'(R0_addr) < DEPTH);
  assign w_wr_in_range = (32'(W0_addr) < DEPTH);
  assign R0_data       = r_rd_data;
  assign R0_valid      = r_rd_valid;

  // FSM state and init pointer registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= StInit;
      r_ptr   <= '0;
    end else begin
      r_state <= w_state_d;
      r_ptr   <= w_ptr_d;
    end
  end

  // Next-state: walk the pointer over every entry, then settle in RUN for good.
  always_comb begin
    w_state_d = r_state;
    w_ptr_d   = r_ptr;
    unique case (r_state)
      StInit: begin
        w_ptr_d = r_ptr + 1'b1;
        if (r_ptr == LastAddr) begin
          w_state_d = StRun;
          w_ptr_d   = '0;
        end
      end
      StRun: begin
        w_state_d = StRun;
      end
      default: begin
        w_state_d = StInit;
        w_ptr_d   = '0;
      end
    endcase
  end

  // Lane merge of write data over the current contents of the write address.
  always_comb begin
    w_wr_old = '0;
    if (w_wr_in_range) w_wr_old = r_mem[W0_addr];
    w_wr_merged = w_wr_old;
    for (int unsigned i = 0; i < MW; i++) begin
      if (W0_mask[i]) w_wr_merged[i*MASK_GRAN +: MASK_GRAN] = W0_data[i*MASK_GRAN +: MASK_GRAN];
    end
  end

  // Single memory write port, shared by the init clearer and user writes.
  always_comb begin
    w_mem_we    = 1'b0;
    w_mem_addr  = '0;
    w_mem_wdata = '0;
    if (!reset) begin
      if (r_state == StInit) begin
        w_mem_we   = 1'b1;
        w_mem_addr = r_ptr;
      end else if (W0_en && w_wr_in_range && (|W0_mask)) begin
        w_mem_we    = 1'b1;
        w_mem_addr  = W0_addr;
        w_mem_wdata = w_wr_merged;
      end
    end
  end

  // Storage array; contents are defined by the init sweep, not by reset.
  always_ff @(posedge clock) begin
    if (w_mem_we) r_mem[w_mem_addr] <= w_mem_wdata;
  end

  // Read word selection; out-of-range addresses read as zero.
  always_comb begin
    w_rd_word = '0;
    if (w_rd_in_range) w_rd_word = r_mem[R0_addr];
`ifdef RAM_1R1W_BYPASS_EN
    if (W0_en && w_rd_in_range && (W0_addr == R0_addr)) w_rd_word = w_wr_merged;
`endif
  end

  // Registered read port; data holds its last value when no read is accepted.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_rd_valid <= 1'b0;
      r_rd_data  <= '0;
    end else begin
      r_rd_valid <= w_run & R0_en;
      if (w_run && R0_en) r_rd_data <= w_rd_word;
    end
  end

endmodule

// File: tb/tb_ram_1r1w_sync.sv
// Directed bench for ram_1r1w_sync at DEPTH=4, WIDTH=16, MASK_GRAN=8.
module tb_ram_1r1w_sync;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        init_busy;
  logic [1:0]  R0_addr = '0;
  logic        R0_en = 1'b0;
  logic [15:0] R0_data;
  logic        R0_valid;
  logic [1:0]  W0_addr = '0;
  logic        W0_en = 1'b0;
  logic [1:0]  W0_mask = '0;
  logic [15:0] W0_data = '0;

  int unsigned n_total = 0;
  int unsigned n_bad   = 0;

  ram_1r1w_sync #(
    .DEPTH    (4),
    .WIDTH    (16),
    .MASK_GRAN(8)
  ) u_dut (
    .clock    (clock),
    .reset    (reset),
    .init_busy(init_busy),
    .R0_addr  (R0_addr),
    .R0_en    (R0_en),
    .R0_data  (R0_data),
    .R0_valid (R0_valid),
    .W0_addr  (W0_addr),
    .W0_en    (W0_en),
    .W0_mask  (W0_mask),
    .W0_data  (W0_data)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are observed 1 time unit after the edge.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [15:0] d, input logic [1:0] m);
    W0_addr = a;
    W0_data = d;
    W0_mask = m;
    W0_en   = 1'b1;
    step();
    W0_en   = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [1:0] a, input logic [15:0] exp);
    R0_addr = a;
    R0_en   = 1'b1;
    step();
    R0_en   = 1'b0;
    chk({tag, "_valid"}, 32'(R0_valid), 32'd1);
    chk({tag, "_data"}, 32'(R0_data), 32'(exp));
  endtask

  logic [15:0] exp_b2b [4];

  initial begin
    // Reset for 3 cycles.
    repeat (3) step();
    chk("rst_busy", 32'(init_busy), 32'd1);
    chk("rst_valid", 32'(R0_valid), 32'd0);
    chk("rst_data", 32'(R0_data), 32'd0);
    reset = 1'b0;

    // INIT lasts exactly 4 cycles; a write in the second cycle is ignored.
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("init_busy_%0d", i), 32'(init_busy), 32'd1);
      chk($sformatf("init_valid_%0d", i), 32'(R0_valid), 32'd0);
      if (i == 1) begin
        W0_addr = 2'd1;
        W0_data = 16'hFFFF;
        W0_mask = 2'b11;
        W0_en   = 1'b1;
      end else begin
        W0_en = 1'b0;
      end
      step();
    end
    W0_en = 1'b0;
    chk("init_done", 32'(init_busy), 32'd0);

    for (int i = 0; i < 4; i++) rd($sformatf("zero_rd%0d", i), 2'(i), 16'h0000);

    // Read not requested: valid drops, data holds.
    step();
    chk("idle_valid", 32'(R0_valid), 32'd0);
    chk("idle_hold", 32'(R0_data), 32'h0000);

    // Masked write.
    wr(2'd2, 16'hABCD, 2'b11);
    wr(2'd2, 16'h1234, 2'b01);
    rd("mask_rd", 2'd2, 16'hAB34);
    wr(2'd2, 16'h9999, 2'b00);
    rd("mask0_rd", 2'd2, 16'hAB34);

    // Same-address collision.
    wr(2'd3, 16'h5555, 2'b11);
    W0_addr = 2'd3;
    W0_data = 16'hAAAA;
    W0_mask = 2'b10;
    W0_en   = 1'b1;
    R0_addr = 2'd3;
    R0_en   = 1'b1;
    step();
    W0_en = 1'b0;
    R0_en = 1'b0;
    chk("coll_valid", 32'(R0_valid), 32'd1);
`ifdef RAM_1R1W_BYPASS_EN
    chk("coll_data", 32'(R0_data), 32'hAA55);
`else
    chk("coll_data", 32'(R0_data), 32'h5555);
`endif
    rd("coll_after", 2'd3, 16'hAA55);

    // Reset during RUN; a read and write issued in the reset cycle are discarded.
    wr(2'd0, 16'h7777, 2'b11);
    reset   = 1'b1;
    R0_addr = 2'd0;
    R0_en   = 1'b1;
    W0_addr = 2'd1;
    W0_data = 16'h9999;
    W0_mask = 2'b11;
    W0_en   = 1'b1;
    step();
    reset = 1'b0;
    W0_en = 1'b0;
    chk("rrun_valid", 32'(R0_valid), 32'd0);
    chk("rrun_data", 32'(R0_data), 32'h0000);
    // R0_en stays high through INIT and must be ignored.
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("rrun_busy_%0d", i), 32'(init_busy), 32'd1);
      chk($sformatf("rrun_ivalid_%0d", i), 32'(R0_valid), 32'd0);
      step();
    end
    R0_en = 1'b0;
    chk("rrun_done", 32'(init_busy), 32'd0);
    chk("rrun_lastvalid", 32'(R0_valid), 32'd0);
    rd("rrun_rd0", 2'd0, 16'h0000);
    rd("rrun_rd1", 2'd1, 16'h0000);

    // Back-to-back reads.
    exp_b2b[0] = 16'h0101;
    exp_b2b[1] = 16'h0202;
    exp_b2b[2] = 16'h0303;
    exp_b2b[3] = 16'h0404;
    for (int i = 0; i < 4; i++) wr(2'(i), exp_b2b[i], 2'b11);
    for (int i = 0; i < 4; i++) begin
      R0_addr = 2'(i);
      R0_en   = 1'b1;
      step();
      chk($sformatf("b2b_valid_%0d", i), 32'(R0_valid), 32'd1);
      chk($sformatf("b2b_data_%0d", i), 32'(R0_data), 32'(exp_b2b[i]));
    end
    R0_en = 1'b0;
    step();
    chk("b2b_end_valid", 32'(R0_valid), 32'd0);
    chk("b2b_end_hold", 32'(R0_data), 32'h0404);
    step();
    chk("b2b_end_hold2", 32'(R0_data), 32'h0404);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
